// File: rtl/velocity_cell_pingpong.sv
// velocity_cell_pingpong: double-buffered per-cell velocity store.
// Reads hit the active bank, writes hit the shadow bank; a swap flips them.
module velocity_cell_pingpong #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  swap_req,
   output logic                  busy,
   output logic                  swap_done,
   output logic                  active_bank,
   output logic [ADDR_WIDTH-1:0] particle_num,
   output logic [ADDR_WIDTH-1:0] wr_count,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, DRAIN, FLIP} state_e;
   typedef enum logic [1:0] {SRC_ZERO, SRC_CNT, SRC_B0, SRC_B1} src_e;

   localparam logic [ADDR_WIDTH:0] PN =
      (ADDR_WIDTH+1)'(PARTICLE_NUM);
   localparam logic [ADDR_WIDTH-1:0] WC_MAX =
      ADDR_WIDTH'(PARTICLE_NUM - 1);

   logic [DATA_WIDTH-1:0] bank0 [PARTICLE_NUM];
   logic [DATA_WIDTH-1:0] bank1 [PARTICLE_NUM];
   logic [DATA_WIDTH-1:0] b0_rd_q, b1_rd_q;

   state_e                state_q, state_d;
   src_e                  src_q, src_d;
   logic                  act_q, act_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] cnt0_q, cnt0_d;
   logic [ADDR_WIDTH-1:0] cnt1_q, cnt1_d;
   logic [ADDR_WIDTH-1:0] rcnt_q, rcnt_d;
   logic [ADDR_WIDTH-1:0] wc_q, wc_d;

   logic idle, rd_fire, wr_fire, rd_in, wr_in;
   logic wr_ram, wr_cnt;

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      done_d  = 1'b0;
      src_d   = SRC_ZERO;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      rcnt_d  = rcnt_q;
      wc_d    = wc_q;
      idle    = (state_q == IDLE);
      rd_fire = rd_en && idle;
      wr_fire = wr_en && idle;
      rd_in   = {1'b0, rd_addr} < PN;
      wr_in   = {1'b0, wr_addr} < PN;
      wr_ram  = wr_fire && wr_in && (wr_addr != '0);
      wr_cnt  = wr_fire && (wr_addr == '0);
      valid_d = rd_fire;
      err_d   = err_q | (!idle && (rd_en || wr_en))
              | (rd_fire && !rd_in) | (wr_fire && !wr_in);

      if (rd_fire && rd_in) begin
         if (rd_addr == '0) begin
            src_d  = SRC_CNT;
            rcnt_d = act_q ? cnt1_q : cnt0_q;
         end else begin
            src_d = act_q ? SRC_B1 : SRC_B0;
         end
      end

      // Count register of the shadow bank takes the low address bits
      if (wr_cnt && act_q)  cnt0_d = wr_data[ADDR_WIDTH-1:0];
      if (wr_cnt && !act_q) cnt1_d = wr_data[ADDR_WIDTH-1:0];
      if (wr_ram && (wc_q != WC_MAX)) wc_d = wc_q + 1'b1;

      unique case (state_q)
         IDLE:  if (swap_req) state_d = DRAIN;
         DRAIN: state_d = FLIP;
         FLIP: begin
            state_d = IDLE;
            act_d   = ~act_q;
            done_d  = 1'b1;
            wc_d    = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= SRC_ZERO;
         act_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         rcnt_q  <= '0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         act_q   <= act_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         rcnt_q  <= rcnt_d;
         wc_q    <= wc_d;
      end
   end

   // Plain synchronous RAM processes so each bank maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_ram && act_q) bank0[wr_addr] <= wr_data;
      if (rd_fire && rd_in) b0_rd_q <= bank0[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (wr_ram && !act_q) bank1[wr_addr] <= wr_data;
      if (rd_fire && rd_in) b1_rd_q <= bank1[rd_addr];
   end

   always_comb begin
      rd_data = '0;
      unique case (src_q)
         SRC_CNT:  rd_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, rcnt_q};
         SRC_B0:   rd_data = b0_rd_q;
         SRC_B1:   rd_data = b1_rd_q;
         default:  rd_data = '0;
      endcase
   end

   assign rd_valid     = valid_q;
   assign busy         = (state_q != IDLE);
   assign swap_done    = done_q;
   assign active_bank  = act_q;
   assign particle_num = act_q ? cnt1_q : cnt0_q;
   assign wr_count     = wc_q;
   assign err          = err_q;

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// tb_velocity_cell_pingpong: scoreboard bench for the ping-pong store.
// Expected read data is queued at issue and popped on rd_valid.
module tb_velocity_cell_pingpong;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en, wr_en, swap_req;
   logic [7:0]  rd_addr, wr_addr;
   logic [95:0] wr_data, rd_data;
   logic        rd_valid, busy, swap_done, active_bank, err;
   logic [7:0]  particle_num, wr_count;

   typedef struct {
      logic [95:0] v;
      bit          care;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   velocity_cell_pingpong dut (
      .clk(clk), .rst_n(rst_n),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .swap_req(swap_req), .busy(busy), .swap_done(swap_done),
      .active_bank(active_bank), .particle_num(particle_num),
      .wr_count(wr_count), .err(err)
   );

   task automatic check(string tag, logic [95:0] got, logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(logic [95:0] v, bit care);
      exp_t e;
      e.v    = v;
      e.care = care;
      sb.push_back(e);
   endtask

   task automatic step(bit re, logic [7:0] ra, bit we, logic [7:0] wa,
                       logic [95:0] wd, bit sw);
      rd_en = re; rd_addr = ra;
      wr_en = we; wr_addr = wa; wr_data = wd;
      swap_req = sw;
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         if (sb.size() == 0) begin
            check("rd_spurious", 1'b1, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.care) check("rd_data", rd_data, mon_e.v);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      rd_en = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_swap_done", swap_done, 0);
      check("rst_active", active_bank, 0);
      check("rst_pnum", particle_num, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      // reads right after reset
      push(96'h0, 1'b1);
      step(1, 8'd0, 0, 8'd0, 96'h0, 0);
      check("t1_valid", rd_valid, 1);
      push(96'h0, 1'b0);
      step(1, 8'd5, 0, 8'd0, 96'h0, 0);
      tick();
      check("t1_valid_low", rd_valid, 0);
      check("t1_pnum", particle_num, 0);
      check("t1_active", active_bank, 0);
      check("t1_err", err, 0);

      // fill shadow bank 1 and swap
      step(0, 8'd0, 1, 8'd0, 96'd3, 0);
      step(0, 8'd0, 1, 8'd1, 96'h0101, 0);
      step(0, 8'd0, 1, 8'd2, 96'h0202, 0);
      step(0, 8'd0, 1, 8'd3, 96'h0303, 0);
      check("t2_wr_count", wr_count, 3);
      check("t2_pnum_pre", particle_num, 0);
      step(0, 8'd0, 0, 8'd0, 96'h0, 1);
      check("t2_busy_e0", busy, 1);
      check("t2_done_e0", swap_done, 0);
      tick();
      check("t2_busy_e1", busy, 1);
      check("t2_done_e1", swap_done, 0);
      tick();
      check("t2_busy_e2", busy, 0);
      check("t2_done_e2", swap_done, 1);
      check("t2_active", active_bank, 1);
      check("t2_pnum", particle_num, 3);
      check("t2_wc_clr", wr_count, 0);
      tick();
      check("t2_done_pulse", swap_done, 0);
      for (int i = 1; i <= 3; i++) begin
         push(96'h0101 * i, 1'b1);
         step(1, 8'(i), 0, 8'd0, 96'h0, 0);
      end
      push(96'd3, 1'b1);
      step(1, 8'd0, 0, 8'd0, 96'h0, 0);

      // seed bank 0, then out-of-range write and read
      step(0, 8'd0, 1, 8'd2, 96'h2222, 0);
      check("t5_wc_pre", wr_count, 1);
      check("t5_err_pre", err, 0);
      push(96'h0, 1'b1);
      step(1, 8'd250, 1, 8'd220, 96'hDEAD, 0);
      check("t5_err", err, 1);
      check("t5_wc", wr_count, 1);
      tick();
      check("t5_err_sticky", err, 1);

      // back-to-back reads, swap on the second, read during DRAIN
      push(96'h0101, 1'b1);
      step(1, 8'd1, 0, 8'd0, 96'h0, 0);
      push(96'h0202, 1'b1);
      step(1, 8'd2, 0, 8'd0, 96'h0, 1);
      check("t3_busy_e0", busy, 1);
      step(1, 8'd3, 0, 8'd0, 96'h0, 0);
      check("t3_busy_e1", busy, 1);
      check("t3_err", err, 1);
      tick();
      check("t3_busy_e2", busy, 0);
      check("t3_done", swap_done, 1);
      check("t3_active", active_bank, 0);
      check("t3_pnum", particle_num, 0);

      // same-cycle read and write of addr 2
      push(96'h2222, 1'b1);
      step(1, 8'd2, 1, 8'd2, 96'hABC, 0);
      push(96'h2222, 1'b1);
      step(1, 8'd2, 0, 8'd0, 96'h0, 0);
      step(0, 8'd0, 0, 8'd0, 96'h0, 1);
      tick();
      tick();
      check("t4_active", active_bank, 1);
      push(96'hABC, 1'b1);
      step(1, 8'd2, 0, 8'd0, 96'h0, 0);
      push(96'd3, 1'b1);
      step(1, 8'd0, 0, 8'd0, 96'h0, 0);
      check("t4_pnum", particle_num, 3);

      // back to bank 0, then reset in FLIP
      step(0, 8'd0, 0, 8'd0, 96'h0, 1);
      tick();
      tick();
      check("t6_active_pre", active_bank, 0);
      tick();
      step(0, 8'd0, 0, 8'd0, 96'h0, 1);
      tick();
      check("t6_busy_flip", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6_active", active_bank, 0);
      check("t6_busy", busy, 0);
      check("t6_pnum", particle_num, 0);
      check("t6_err", err, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_done", swap_done, 0);
      end
      rst_n = 1'b1;
      tick();
      check("t6_active_post", active_bank, 0);

      // fresh err from a read issued while busy
      step(0, 8'd0, 0, 8'd0, 96'h0, 1);
      check("t7_err_pre", err, 0);
      step(1, 8'd1, 0, 8'd0, 96'h0, 0);
      check("t7_err", err, 1);
      step(0, 8'd0, 1, 8'd1, 96'h5555, 1);
      check("t7_done", swap_done, 1);
      check("t7_active", active_bank, 1);
      check("t7_wc", wr_count, 0);
      tick();
      tick();
      check("t7_busy_no_swap", busy, 0);
      check("t7_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
